bnn_layer_sched: RTL

//  Sequencer for the conv_mix conv/ReLU/maxpool datapath. Runs two BNN conv layers back to back:

---
 rtl/bnn_layer_sched.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/bnn_layer_sched.sv
// bnn_layer_sched: sequences two BNN conv layers (weight load, feature stream, result capture, datapath flush).
// Optional RUN-state watchdog is compiled in when BNN_SCHED_WDOG_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for go
// S_LOAD_W| stepping weight ROM, strobing kernel bits one cycle behind
// S_RUN   | datapath running, features streamed, pooled results written
// S_FLUSH | two cycles of datapath reset between layers / after abort
// S_FIN   | one-cycle all_done pulse, then back to idle
module bnn_layer_sched #(
    parameter int KBITS    = 25,
    parameter int L0_PIX   = 784,
    parameter int L1_PIX   = 144,
    parameter int L0_OUT   = 144,
    parameter int L1_OUT   = 16,
    parameter int AW       = 10,
    parameter int WDOG_MAX = 4095
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_go,
    output logic [5:0]    o_w_rd_addr,
    input  logic          i_w_rd_data,
    output logic [AW-1:0] o_fm_rd_addr,
    input  logic [31:0]   i_fm_rd_data,
    output logic          o_conv_rstn,
    output logic          o_conv_start,
    output logic          o_conv_state,
    output logic          o_conv_weight_en,
    output logic          o_conv_weight,
    output logic [31:0]   o_conv_din,
    input  logic          i_conv_din_ready,
    input  logic          i_conv_ovalid,
    input  logic [31:0]   i_conv_dout,
    output logic          o_out_wr_en,
    output logic [AW-1:0] o_out_wr_addr,
    output logic [31:0]   o_out_wr_data,
    output logic          o_busy,
    output logic          o_layer_done,
    output logic          o_all_done,
    output logic          o_err
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_RUN, S_FLUSH, S_FIN} state_t;

    localparam logic [5:0]    KB          = 6'(KBITS);
    localparam logic [AW-1:0] L0_PIX_LAST = AW'(L0_PIX - 1);
    localparam logic [AW-1:0] L1_PIX_LAST = AW'(L1_PIX - 1);
    localparam logic [AW-1:0] L0_OUT_N    = AW'(L0_OUT);
    localparam logic [AW-1:0] L1_OUT_N    = AW'(L1_OUT);

    state_t        r_state;
    logic          r_layer;
    logic          r_weight_en;
    logic          r_conv_start;
    logic          r_flush;
    logic          r_flush_cnt;
    logic          r_abort;
    logic          r_layer_done;
    logic          r_all_done;
    logic [5:0]    r_w_rd_addr;
    logic [5:0]    r_w_idx;
    logic [AW-1:0] r_fm_ptr;
    logic [AW-1:0] r_out_cnt;

    logic [AW-1:0] w_pix_last;
    logic [AW-1:0] w_out_num;
    logic [AW-1:0] w_out_base;
    logic          w_wr;
    logic          w_last_wr;
    logic          w_wdog_trip;

    assign w_pix_last = r_layer ? L1_PIX_LAST : L0_PIX_LAST;
    assign w_out_num  = r_layer ? L1_OUT_N : L0_OUT_N;
    assign w_out_base = r_layer ? L0_OUT_N : '0;
    // results arriving outside RUN or past the layer quota are dropped
    assign w_wr       = (r_state == S_RUN) && i_conv_ovalid && (r_out_cnt < w_out_num);
    assign w_last_wr  = w_wr && (r_out_cnt == w_out_num - AW'(1));

    assign o_w_rd_addr      = r_w_rd_addr;
    assign o_fm_rd_addr     = r_fm_ptr;
    assign o_conv_din       = i_fm_rd_data;
    assign o_conv_rstn      = i_rstn & ~r_flush;
    assign o_conv_start     = r_conv_start;
    assign o_conv_state     = r_layer;
    assign o_conv_weight_en = r_weight_en;
    assign o_conv_weight    = r_weight_en & i_w_rd_data;
    assign o_out_wr_en      = w_wr;
    assign o_out_wr_addr    = w_out_base + r_out_cnt;
    assign o_out_wr_data    = i_conv_dout;
    assign o_busy           = (r_state != S_IDLE);
    assign o_layer_done     = r_layer_done;
    assign o_all_done       = r_all_done;

`ifdef BNN_SCHED_WDOG_EN
    localparam logic [11:0] WD_LIM = 12'(WDOG_MAX);

    logic [11:0] r_wdog;
    logic        r_err;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state != S_RUN || i_conv_ovalid)
                r_wdog <= '0;
            else if (r_wdog != WD_LIM)
                r_wdog <= r_wdog + 12'd1;

            if (w_wdog_trip)
                r_err <= 1'b1;
            else if (r_state == S_IDLE && i_go)
                r_err <= 1'b0;
        end
    end

    assign w_wdog_trip = (r_state == S_RUN) && !i_conv_ovalid && (r_wdog == WD_LIM);
    assign o_err       = r_err;
`else
    assign w_wdog_trip = 1'b0;
    assign o_err       = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state      <= S_IDLE;
            r_layer      <= 1'b0;
            r_weight_en  <= 1'b0;
            r_conv_start <= 1'b0;
            r_flush      <= 1'b0;
            r_flush_cnt  <= 1'b0;
            r_abort      <= 1'b0;
            r_layer_done <= 1'b0;
            r_all_done   <= 1'b0;
            r_w_rd_addr  <= '0;
            r_w_idx      <= '0;
            r_fm_ptr     <= '0;
            r_out_cnt    <= '0;
        end else begin
            r_layer_done <= 1'b0;
            r_all_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_go) begin
                        r_state     <= S_LOAD_W;
                        r_layer     <= 1'b0;
                        r_fm_ptr    <= '0;
                        r_out_cnt   <= '0;
                        r_w_rd_addr <= '0;
                        r_w_idx     <= '0;
                        r_abort     <= 1'b0;
                    end
                end
                S_LOAD_W: begin
                    // ROM data lags the address by one cycle, so the strobe does too
                    if (r_w_idx < KB) begin
                        r_weight_en <= 1'b1;
                        r_w_idx     <= r_w_idx + 6'd1;
                        if (r_w_idx < KB - 6'd1)
                            r_w_rd_addr <= r_w_rd_addr + 6'd1;
                    end else begin
                        r_weight_en  <= 1'b0;
                        r_conv_start <= 1'b1;
                        r_state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_conv_din_ready && r_fm_ptr != w_pix_last)
                        r_fm_ptr <= r_fm_ptr + AW'(1);
                    if (w_wr)
                        r_out_cnt <= r_out_cnt + AW'(1);
                    if (w_last_wr) begin
                        r_state      <= S_FLUSH;
                        r_layer_done <= 1'b1;
                        r_conv_start <= 1'b0;
                        r_flush      <= 1'b1;
                        r_flush_cnt  <= 1'b0;
                    end else if (w_wdog_trip) begin
                        r_state      <= S_FLUSH;
                        r_abort      <= 1'b1;
                        r_conv_start <= 1'b0;
                        r_flush      <= 1'b1;
                        r_flush_cnt  <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    r_fm_ptr  <= '0;
                    r_out_cnt <= '0;
                    if (!r_flush_cnt) begin
                        r_flush_cnt <= 1'b1;
                    end else begin
                        r_flush     <= 1'b0;
                        r_flush_cnt <= 1'b0;
                        if (r_abort) begin
                            r_state     <= S_IDLE;
                            r_layer     <= 1'b0;
                            r_w_rd_addr <= '0;
                        end else if (!r_layer) begin
                            r_state     <= S_LOAD_W;
                            r_layer     <= 1'b1;
                            r_w_rd_addr <= KB;
                            r_w_idx     <= '0;
                        end else begin
                            r_state    <= S_FIN;
                            r_all_done <= 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    r_state     <= S_IDLE;
                    r_layer     <= 1'b0;
                    r_w_rd_addr <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
